// File: rtl/jk_cmd_driver.sv
// Command sequencer for a level-sensitive JK latch: buffers {j,k} ops in a FIFO and replays
// each one as a setup / enable-pulse / hold waveform while tracking the latch output.
module jk_cmd_driver #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned PULSE_CYC  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cmd_valid,
    input  logic [1:0]                           cmd_op,
    output logic                                 cmd_ready,
    output logic                                 j,
    output logic                                 k,
    output logic                                 en,
    output logic                                 q_model,
    output logic                                 busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

    localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned MaxCyc = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned CycW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
    localparam logic [CycW-1:0] SetupLast = CycW'(SETUP_CYC - 1);
    localparam logic [CycW-1:0] PulseLast = CycW'(PULSE_CYC - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_e;

    state_e            r_state;
    logic [1:0]        r_op;
    logic [CycW-1:0]   r_cyc;
    logic              r_j;
    logic              r_k;
    logic              r_en;
    logic              r_q;

    logic [1:0]        r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [CntW-1:0]   r_count;

    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_head;

    assign w_full = (r_count == CntW'(FIFO_DEPTH));
    assign w_push = cmd_valid & ~w_full;
    // The head is consumed only when the sequencer is free to start a new waveform.
    assign w_pop  = (r_count != '0) & ((r_state == StIdle) | (r_state == StHold));
    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_op    <= 2'b00;
            r_cyc   <= '0;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
            r_en    <= 1'b0;
            r_q     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_state <= StSetup;
                        r_op    <= w_head;
                        r_j     <= w_head[1];
                        r_k     <= w_head[0];
                        r_cyc   <= '0;
                    end
                end
                StSetup: begin
                    if (r_cyc == SetupLast) begin
                        r_state <= StPulse;
                        r_en    <= 1'b1;
                        r_cyc   <= '0;
                    end else begin
                        r_cyc <= r_cyc + CycW'(1);
                    end
                end
                StPulse: begin
                    if (r_cyc == PulseLast) begin
                        r_state <= StHold;
                        r_en    <= 1'b0;
                        r_cyc   <= '0;
                        // Latch samples j/k while en is high; its q settles as en falls.
                        case (r_op)
                            2'b01:   r_q <= 1'b0;
                            2'b10:   r_q <= 1'b1;
                            2'b11:   r_q <= ~r_q;
                            default: r_q <= r_q;
                        endcase
                    end else begin
                        r_cyc <= r_cyc + CycW'(1);
                    end
                end
                StHold: begin
                    if (w_pop) begin
                        r_state <= StSetup;
                        r_op    <= w_head;
                        r_j     <= w_head[1];
                        r_k     <= w_head[0];
                        r_cyc   <= '0;
                    end else begin
                        r_state <= StIdle;
                        r_j     <= 1'b0;
                        r_k     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready  = ~w_full;
    assign j          = r_j;
    assign k          = r_k;
    assign en         = r_en;
    assign q_model    = r_q;
    assign fifo_count = r_count;
    assign busy       = (r_state != StIdle) | (r_count != '0);

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Scoreboard bench for jk_cmd_driver: two instances (1/1 and 2/3 timing) share one stimulus
// stream and are checked against a per-instance command-schedule model.
module tb_jk_cmd_driver;

    localparam int Depth = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;

    logic [1:0] rdy, oj, ok, oen, oq, obusy;
    logic [2:0] cnt0, cnt1;

    jk_cmd_driver #(.FIFO_DEPTH(4), .SETUP_CYC(1), .PULSE_CYC(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(rdy[0]), .j(oj[0]), .k(ok[0]), .en(oen[0]), .q_model(oq[0]),
        .busy(obusy[0]), .fifo_count(cnt0)
    );

    jk_cmd_driver #(.FIFO_DEPTH(4), .SETUP_CYC(2), .PULSE_CYC(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(rdy[1]), .j(oj[1]), .k(ok[1]), .en(oen[1]), .q_model(oq[1]),
        .busy(obusy[1]), .fifo_count(cnt1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        logic       q;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    // Model: a command occupies the driver for S+P+1 edges after it is taken from the queue.
    int         m_rem [2];
    int         m_cnt [2];
    int         m_head[2];
    logic [1:0] m_mem [2][Depth];
    logic [1:0] m_op  [2];
    logic       m_q   [2];
    logic       m_accq[2];
    bit         m_acc [2];

    logic [1:0] pulse_jk[2];
    logic       prev_en [2];

    function automatic int s_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int p_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic apply(input logic q, input logic [1:0] op);
        case (op)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

    task automatic chk(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", name, i, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_rem[i]  = 0;
            m_cnt[i]  = 0;
            m_head[i] = 0;
            m_op[i]   = 2'b00;
            m_q[i]    = 1'b0;
            m_accq[i] = 1'b0;
            m_acc[i]  = 1'b0;
        end
        sb0.delete();
        sb1.delete();
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_clear();
            end else begin
                for (int i = 0; i < 2; i++) begin
                    bit   acc;
                    exp_t e;
                    acc = cmd_valid && (m_cnt[i] < Depth);
                    m_acc[i] = acc;
                    if (m_rem[i] > 0) m_rem[i]--;
                    if (m_rem[i] == 1) m_q[i] = apply(m_q[i], m_op[i]);
                    if (m_rem[i] == 0) begin
                        if (m_cnt[i] > 0) begin
                            m_op[i]   = m_mem[i][m_head[i]];
                            m_head[i] = (m_head[i] + 1) % Depth;
                            m_cnt[i]--;
                            m_rem[i]  = s_of(i) + p_of(i) + 1;
                        end else begin
                            m_op[i] = 2'b00;
                        end
                    end
                    if (acc) begin
                        m_mem[i][(m_head[i] + m_cnt[i]) % Depth] = cmd_op;
                        m_cnt[i]++;
                        m_accq[i] = apply(m_accq[i], cmd_op);
                        e.op = cmd_op;
                        e.q  = m_accq[i];
                        if (i == 0) sb0.push_back(e);
                        else        sb1.push_back(e);
                    end
                end
            end
        end
    end

    task automatic sb_check(input int i, input logic q, input logic [1:0] jk);
        exp_t e;
        int   n;
        n = (i == 0) ? sb0.size() : sb1.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty inst%0d t=%0t: pulse with op %0d but no command pending",
                     i, $time, jk);
            return;
        end
        if (i == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        chk("pulse_op", i, int'(jk), int'(e.op));
        chk("pulse_q", i, int'(q), int'(e.q));
    endtask

    // Monitor: per-cycle output checks plus a scoreboard pop at each falling en.
    initial begin
        prev_en[0] = 1'b0;
        prev_en[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en[0] = 1'b0;
                prev_en[1] = 1'b0;
                continue;
            end
            for (int i = 0; i < 2; i++) begin
                int   exp_en;
                int   cnt;
                logic [1:0] jk;
                exp_en = (m_rem[i] >= 2 && m_rem[i] <= p_of(i) + 1) ? 1 : 0;
                cnt    = (i == 0) ? int'(cnt0) : int'(cnt1);
                jk     = {oj[i], ok[i]};
                chk("en", i, int'(oen[i]), exp_en);
                chk("jk", i, int'(jk), int'(m_op[i]));
                chk("q_model", i, int'(oq[i]), int'(m_q[i]));
                chk("fifo_count", i, cnt, m_cnt[i]);
                chk("cmd_ready", i, int'(rdy[i]), (m_cnt[i] < Depth) ? 1 : 0);
                chk("busy", i, int'(obusy[i]), (m_rem[i] > 0 || m_cnt[i] > 0) ? 1 : 0);
                if (oen[i]) begin
                    if (!prev_en[i]) pulse_jk[i] = jk;
                    else chk("jk_stable_en", i, int'(jk), int'(pulse_jk[i]));
                end else if (prev_en[i]) begin
                    sb_check(i, oq[i], pulse_jk[i]);
                end
                prev_en[i] = oen[i];
            end
        end
    end

    // Holds cmd_valid until instance 0 takes the op; returns at a negedge with valid still high.
    task automatic push_op(input logic [1:0] op);
        bit done;
        done = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        for (int n = 0; n < 50 && !done; n++) begin
            @(posedge clk);
            #1;
            done = m_acc[0];
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout t=%0t: op %0d never accepted", $time, op);
        end
        @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < budget && !idle; n++) begin
            @(negedge clk);
            idle = (m_rem[0] == 0 && m_cnt[0] == 0 && m_rem[1] == 0 && m_cnt[1] == 0);
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout t=%0t: model never went idle", $time);
        end
    endtask

    initial begin
        logic [1:0] seq [5];
        seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b11; seq[4] = 2'b00;

        // Reset with input activity.
        #1 rst_n = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_en", i, int'(oen[i]), 0);
            chk("rst_jk", i, int'({oj[i], ok[i]}), 0);
            chk("rst_q", i, int'(oq[i]), 0);
            chk("rst_count", i, (i == 0) ? int'(cnt0) : int'(cnt1), 0);
        end
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (3) @(negedge clk);

        // Single set.
        push_op(2'b10);
        cmd_valid = 1'b0;
        wait_drain(40);
        chk("single_set_q", 0, int'(oq[0]), 1);

        // Back-to-back sequence: final q after 10,11,01,11,00 is 1.
        foreach (seq[n]) push_op(seq[n]);
        cmd_valid = 1'b0;
        wait_drain(100);
        chk("seq_final_q", 0, int'(oq[0]), 1);
        chk("seq_final_q", 1, int'(oq[1]), 1);

        // Fill: seven consecutive offers; instance 0 is full after the sixth.
        for (int n = 0; n < 7; n++) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom_range(3));
            @(negedge clk);
            if (n == 5) chk("full_ready", 0, int'(rdy[0]), 0);
            if (n == 6) chk("full_count_held", 0, int'(cnt0), 4);
        end
        cmd_valid = 1'b0;

        // Reset while en is high on instance 0.
        begin
            bit hit;
            hit = 1'b0;
            for (int n = 0; n < 20 && !hit; n++) begin
                if (m_rem[0] >= 2 && m_rem[0] <= p_of(0) + 1) hit = 1'b1;
                else @(negedge clk);
            end
            chk("en_seen_before_reset", 0, int'(oen[0]), 1);
        end
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_rst_en", i, int'(oen[i]), 0);
            chk("async_rst_busy", i, int'(obusy[i]), 0);
            chk("async_rst_q", i, int'(oq[i]), 0);
        end
        chk("async_rst_count", 0, int'(cnt0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cmd_valid = ($urandom_range(3) != 0);
            cmd_op    = 2'($urandom_range(3));
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_drain(200);
        repeat (3) @(negedge clk);
        chk("sb_drained", 0, sb0.size(), 0);
        chk("sb_drained", 1, sb1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
